// File: rtl/icache_tag_array_assoc.sv
// N-way set-associative instruction-cache tag/valid store.
// Registered lookup (hit, hit way, victim, multi-hit), per-set round-robin
// replacement, single-line invalidate and a sequenced full flush.
module icache_tag_array_assoc #(
  parameter int unsigned NUM_SETS = 64,
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned TAG_W    = 22,
  parameter int unsigned IDX_W    = $clog2(NUM_SETS),
  parameter int unsigned WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_hit_way,
  output logic [WAY_W-1:0] rsp_victim_way,
  output logic             rsp_multi_hit,
  input  logic             update_valid,
  input  logic [IDX_W-1:0] update_index,
  input  logic [WAY_W-1:0] update_way,
  input  logic [TAG_W-1:0] update_tag,
  input  logic             inval_valid,
  input  logic [IDX_W-1:0] inval_index,
  input  logic [TAG_W-1:0] inval_tag,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_next;
  logic             flush_busy_next, flush_done_next;
  logic             busy;

  logic [TAG_W-1:0]    tag_mem   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];
  logic [WAY_W-1:0]    rr_ptr    [NUM_SETS];

  logic                lk_hit, lk_multi, lk_free;
  logic [WAY_W-1:0]    lk_hit_way, lk_victim;
  logic [NUM_WAYS-1:0] inval_hit;
  logic [WAY_W-1:0]    upd_way, rr_next;

  assign busy = (state == ST_FLUSH);

  // Single-way configurations only ever address way 0
  assign upd_way = (NUM_WAYS > 1) ? update_way : '0;
  assign rr_next = (NUM_WAYS > 1) ? WAY_W'(update_way + 1'b1) : '0;

  // Lookup compare on pre-edge contents: lowest matching way, lowest free way
  always_comb begin
    lk_hit     = 1'b0;
    lk_multi   = 1'b0;
    lk_free    = 1'b0;
    lk_hit_way = '0;
    lk_victim  = rr_ptr[lookup_index];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_mem[lookup_index][w] && (tag_mem[lookup_index][w] == lookup_tag)) begin
        if (lk_hit) begin
          lk_multi = 1'b1;
        end else begin
          lk_hit_way = WAY_W'(w);
        end
        lk_hit = 1'b1;
      end
      if (!valid_mem[lookup_index][w] && !lk_free) begin
        lk_victim = WAY_W'(w);
        lk_free   = 1'b1;
      end
    end
  end

  // Ways in the invalidate set currently holding the invalidate tag
  always_comb begin
    inval_hit = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      inval_hit[w] = valid_mem[inval_index][w] && (tag_mem[inval_index][w] == inval_tag);
    end
  end

  // Tag/valid/rr storage; flush walk has priority, update overrides invalidate on its way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        rr_ptr[s]    <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          tag_mem[s][w] <= '0;
        end
      end
    end else if (busy) begin
      valid_mem[flush_cnt[IDX_W-1:0]] <= '0;
      rr_ptr[flush_cnt[IDX_W-1:0]]    <= '0;
    end else begin
      if (inval_valid) begin
        valid_mem[inval_index] <= valid_mem[inval_index] & ~inval_hit;
      end
      if (update_valid) begin
        tag_mem[update_index][upd_way]   <= update_tag;
        valid_mem[update_index][upd_way] <= 1'b1;
        rr_ptr[update_index]             <= rr_next;
      end
    end
  end

  // Registered lookup response; result fields hold between lookups
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_hit_way    <= '0;
      rsp_victim_way <= '0;
      rsp_multi_hit  <= 1'b0;
    end else begin
      rsp_valid <= lookup_valid;
      if (lookup_valid) begin
        rsp_hit        <= lk_hit && !busy;
        rsp_hit_way    <= lk_hit_way;
        rsp_victim_way <= lk_victim;
        rsp_multi_hit  <= lk_multi && !busy;
      end
    end
  end

  // Flush FSM state register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      flush_cnt  <= flush_cnt_next;
      flush_busy <= flush_busy_next;
      flush_done <= flush_done_next;
    end
  end

  // Flush FSM next state: walk every set once, then return to idle
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      ST_IDLE: begin
        if (flush_req) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = '0;
        end
      end
      ST_FLUSH: begin
        flush_cnt_next = flush_cnt + 1'b1;
        if (flush_cnt == CNT_W'(NUM_SETS - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Flush FSM outputs: busy tracks the flush state, done pulses on exit
  always_comb begin
    flush_busy_next = (state_next == ST_FLUSH);
    flush_done_next = (state == ST_FLUSH) && (state_next == ST_IDLE);
  end

endmodule

// File: tb/tb_icache_tag_array_assoc.sv
// Scoreboard bench for icache_tag_array_assoc: a behavioural array model
// predicts each lookup response; a negedge monitor pops and compares.
module tb_icache_tag_array_assoc;

  localparam int unsigned NUM_SETS = 64;
  localparam int unsigned NUM_WAYS = 2;
  localparam int unsigned TAG_W    = 22;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned WAY_W    = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             lookup_valid, update_valid, inval_valid, flush_req;
  logic [IDX_W-1:0] lookup_index, update_index, inval_index;
  logic [TAG_W-1:0] lookup_tag, update_tag, inval_tag;
  logic [WAY_W-1:0] update_way;
  logic             rsp_valid, rsp_hit, rsp_multi_hit, flush_busy, flush_done;
  logic [WAY_W-1:0] rsp_hit_way, rsp_victim_way;

  icache_tag_array_assoc #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_hit_way(rsp_hit_way),
    .rsp_victim_way(rsp_victim_way), .rsp_multi_hit(rsp_multi_hit),
    .update_valid(update_valid), .update_index(update_index), .update_way(update_way),
    .update_tag(update_tag),
    .inval_valid(inval_valid), .inval_index(inval_index), .inval_tag(inval_tag),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             multi;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: plain arrays of lines plus flush progress
  logic [TAG_W-1:0] m_tag [NUM_SETS][NUM_WAYS];
  bit               m_val [NUM_SETS][NUM_WAYS];
  int               m_rr  [NUM_SETS];
  bit               m_busy, m_done;
  int               m_cnt;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        m_val[s][w] = 1'b0;
        m_tag[s][w] = '0;
      end
    end
    m_busy = 1'b0;
    m_done = 1'b0;
    m_cnt  = 0;
  endfunction

  task automatic idle_inputs();
    lookup_valid = 1'b0; update_valid = 1'b0; inval_valid = 1'b0; flush_req = 1'b0;
  endtask

  // One clock: predict the lookup, advance the model, then check handshake
  task automatic step();
    exp_t e;
    int   nmatch;
    bit   free;
    bit   busy_pre;
    busy_pre = m_busy;
    if (lookup_valid) begin
      e = '0;
      nmatch = 0;
      free = 1'b0;
      e.victim = WAY_W'(m_rr[lookup_index]);
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (m_val[lookup_index][w] && m_tag[lookup_index][w] == lookup_tag) begin
          if (nmatch == 0) e.hit_way = WAY_W'(w);
          nmatch++;
        end
        if (!m_val[lookup_index][w] && !free) begin
          e.victim = WAY_W'(w);
          free = 1'b1;
        end
      end
      e.hit   = (nmatch > 0) && !busy_pre;
      e.multi = (nmatch > 1) && !busy_pre;
      sbq.push_back(e);
    end
    m_done = 1'b0;
    if (busy_pre) begin
      for (int w = 0; w < NUM_WAYS; w++) m_val[m_cnt][w] = 1'b0;
      m_rr[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == NUM_SETS) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      if (inval_valid)
        for (int w = 0; w < NUM_WAYS; w++)
          if (m_tag[inval_index][w] == inval_tag) m_val[inval_index][w] = 1'b0;
      if (update_valid) begin
        m_tag[update_index][update_way] = update_tag;
        m_val[update_index][update_way] = 1'b1;
        m_rr[update_index] = (int'(update_way) + 1) % NUM_WAYS;
      end
      if (flush_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
    check("flush_busy", flush_busy, m_busy);
    check("flush_done", flush_done, m_done);
    idle_inputs();
  endtask

  task automatic do_lookup(input int idx, input int tag);
    lookup_valid = 1'b1;
    lookup_index = IDX_W'(idx);
    lookup_tag   = TAG_W'(tag);
  endtask

  task automatic do_update(input int idx, input int way, input int tag);
    update_valid = 1'b1;
    update_index = IDX_W'(idx);
    update_way   = WAY_W'(way);
    update_tag   = TAG_W'(tag);
  endtask

  task automatic do_inval(input int idx, input int tag);
    inval_valid = 1'b1;
    inval_index = IDX_W'(idx);
    inval_tag   = TAG_W'(tag);
  endtask

  // Monitor: every presented response must match the oldest prediction
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no lookup outstanding at t=%0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_hit", rsp_hit, mon_e.hit);
        if (mon_e.hit) check("rsp_hit_way", rsp_hit_way, mon_e.hit_way);
        check("rsp_victim_way", rsp_victim_way, mon_e.victim);
        check("rsp_multi_hit", rsp_multi_hit, mon_e.multi);
      end
    end
  end

  int busy_cycles, done_pulses, guard;

  initial begin
    idle_inputs();
    lookup_index = '0; lookup_tag = '0; update_index = '0; update_way = '0;
    update_tag = '0; inval_index = '0; inval_tag = '0;
    model_reset();
    rst_n = 1'b0;
    #12;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_hit", rsp_hit, 0);
    check("reset_victim", rsp_victim_way, 0);
    check("reset_flush_busy", flush_busy, 0);
    check("reset_flush_done", flush_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    do_lookup(3, 'h7); step();
    do_update(5, 0, 'h1234); step();
    do_update(5, 1, 'h2345); step();
    do_lookup(5, 'h2345); step();
    do_lookup(5, 'h0AAA); step();
    do_update(5, 0, 'h3333); do_lookup(5, 'h1234); step();   // read-before-write
    do_lookup(5, 'h1234); step();
    do_inval(5, 'h2345); step();
    do_lookup(5, 'h2345); step();
    do_inval(5, 'h3333); do_update(5, 1, 'h2345); step();
    do_lookup(5, 'h2345); step();
    do_update(6, 0, 'h55); step();
    do_update(6, 1, 'h55); step();
    do_lookup(6, 'h55); step();                              // multi-hit
    do_inval(6, 'h55); step();
    do_lookup(6, 'h55); step();

    // Randomized traffic on a small set/tag space to provoke hits and conflicts
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 7) do_lookup($urandom_range(0, 7), $urandom_range(1, 4));
      if ($urandom_range(0, 9) < 3) do_update($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(1, 4));
      if ($urandom_range(0, 9) < 2) do_inval($urandom_range(0, 7), $urandom_range(1, 4));
      flush_req = ($urandom_range(0, 149) == 0);
      step();
    end
    guard = 0;
    while (m_busy && guard < 200) begin guard++; step(); end

    // Fill every set, then flush with lookups and an ignored update mid-flush
    for (int s = 0; s < NUM_SETS; s++) begin
      do_update(s, 0, 'h100 + s); step();
      do_update(s, 1, 'h200 + s); step();
    end
    do_lookup(9, 'h209); step();
    flush_req = 1'b1; step();
    busy_cycles = 0;
    done_pulses = 0;
    guard = 0;
    while (flush_busy && guard < 200) begin
      guard++;
      busy_cycles++;
      if (busy_cycles == 10) do_update(0, 0, 'h777);
      do_lookup($urandom_range(0, NUM_SETS - 1), 'h100 + $urandom_range(0, NUM_SETS - 1));
      step();
      if (flush_done) done_pulses++;
    end
    step();
    if (flush_done) done_pulses++;
    check("flush_busy_cycles", busy_cycles, NUM_SETS);
    check("flush_done_pulses", done_pulses, 1);
    do_lookup(0, 'h777); step();
    for (int s = 0; s < NUM_SETS; s += 7) begin
      do_lookup(s, 'h200 + s); step();
    end

    // Reset asserted part-way through a flush
    for (int s = 0; s < 8; s++) begin
      do_update(s, 0, 'h300 + s); step();
    end
    flush_req = 1'b1; step();
    for (int i = 0; i < 19; i++) begin
      do_lookup($urandom_range(0, 7), 'h300 + $urandom_range(0, 7)); step();
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_flush_busy", flush_busy, 0);
    check("abort_flush_done", flush_done, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    sbq.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 8; s++) begin
      do_lookup(s, 'h300 + s); step();
    end
    do_lookup(20, 0); step();
    repeat (3) step();

    @(negedge clk); #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
